// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module  : mc_ctrl_pkg
// Brief   : Shared encodings for the multicycle MIPS control FSM.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXECUTE = 4'd2,
        ST_ALU_WB  = 4'd3,
        ST_ADDR    = 4'd4,
        ST_MEM     = 4'd5,
        ST_LOAD_WB = 4'd6,
        ST_BRANCH  = 4'd7,
        ST_JUMP    = 4'd8,
        ST_TRAP    = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b001001;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_SB    = 6'b010001;
    localparam logic [5:0] OP_MOVE  = 6'b100000;
    localparam logic [5:0] OP_BEQ   = 6'b100001;
    localparam logic [5:0] OP_BNE   = 6'b100011;
    localparam logic [5:0] OP_J     = 6'b111000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_ADD = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // fetch/branch mark states whose PC/IR enables are qualified by live inputs
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       fetch;
        logic       pc_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       byte_op;
        logic       move;
        logic       branch;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/opcode_class_decode.sv
// ============================================================================
// Module  : opcode_class_decode
// Brief   : Combinational opcode classifier with illegal-opcode detection.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module opcode_class_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic                is_r,
    output logic                is_alui,
    output logic                is_load,
    output logic                is_store,
    output logic                is_branch,
    output logic                is_jump,
    output logic                is_move,
    output logic                is_byte,
    output logic                illegal
);

    logic       w_upper_zero;
    logic [5:0] w_op;

    assign w_op = opcode[5:0];

    generate
        if (OPCODE_W > 6) begin : g_upper_check
            assign w_upper_zero = ~|opcode[OPCODE_W-1:6];
        end else begin : g_no_upper
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        is_r      = 1'b0;
        is_alui   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_move   = 1'b0;
        if (w_upper_zero) begin
            case (w_op)
                OP_RTYPE:                  is_r      = 1'b1;
                OP_ADDI, OP_ORI, OP_SLTI:  is_alui   = 1'b1;
                OP_LW, OP_LB:              is_load   = 1'b1;
                OP_SW, OP_SB:              is_store  = 1'b1;
                OP_BEQ, OP_BNE:            is_branch = 1'b1;
                OP_J:                      is_jump   = 1'b1;
                OP_MOVE:                   is_move   = 1'b1;
                default:                   ;
            endcase
        end
    end

    assign is_byte = (is_load | is_store) & w_op[0];
    assign illegal = ~(is_r | is_alui | is_load | is_store | is_branch | is_jump | is_move);

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module  : multicycle_control_fsm
// Brief   : Multicycle MIPS control FSM with memory handshake timeout and traps.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_src,
    output logic                byte_op,
    output logic                move,
    output logic                trap,
    output logic [3:0]          state_o
);

    localparam int              CNT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic             w_is_r, w_is_alui, w_is_load, w_is_store, w_is_branch;
    logic             w_is_jump, w_is_move, w_is_byte, w_illegal;
    logic [5:0]       w_op;
    logic             w_taken;
    state_t           w_next;
    ctrl_t            w_out;

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic             r_trap;
    logic [CNT_W-1:0] r_wait_cnt;

    opcode_class_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_class (
        .opcode    (opcode),
        .is_r      (w_is_r),
        .is_alui   (w_is_alui),
        .is_load   (w_is_load),
        .is_store  (w_is_store),
        .is_branch (w_is_branch),
        .is_jump   (w_is_jump),
        .is_move   (w_is_move),
        .is_byte   (w_is_byte),
        .illegal   (w_illegal)
    );

    assign w_op = opcode[5:0];

    function automatic state_t next_state(input state_t st, input logic rdy,
                                          input logic [CNT_W-1:0] cnt);
        next_state = ST_TRAP;
        case (st)
            ST_FETCH: begin
                if (rdy)                   next_state = ST_DECODE;
                else if (cnt == C_WAIT_LAST) next_state = ST_TRAP;
                else                       next_state = ST_FETCH;
            end
            ST_DECODE: begin
                if (w_illegal)                           next_state = ST_TRAP;
                else if (w_is_r | w_is_alui | w_is_move) next_state = ST_EXECUTE;
                else if (w_is_load | w_is_store)         next_state = ST_ADDR;
                else if (w_is_branch)                    next_state = ST_BRANCH;
                else if (w_is_jump)                      next_state = ST_JUMP;
            end
            ST_EXECUTE: next_state = ST_ALU_WB;
            ST_ALU_WB:  next_state = ST_FETCH;
            ST_ADDR:    next_state = ST_MEM;
            ST_MEM: begin
                if (rdy)                   next_state = w_is_load ? ST_LOAD_WB : ST_FETCH;
                else if (cnt == C_WAIT_LAST) next_state = ST_TRAP;
                else                       next_state = ST_MEM;
            end
            ST_LOAD_WB: next_state = ST_FETCH;
            ST_BRANCH:  next_state = ST_FETCH;
            ST_JUMP:    next_state = ST_FETCH;
            default:    next_state = ST_TRAP;
        endcase
    endfunction

    // Control word for a state; opcode is stable whenever it is consulted here
    function automatic ctrl_t ctrl_for(input state_t st);
        ctrl_for = '0;
        case (st)
            ST_FETCH: begin
                ctrl_for.mem_req   = 1'b1;
                ctrl_for.fetch     = 1'b1;
                ctrl_for.alu_src_b = SRCB_FOUR;
                ctrl_for.alu_op    = ALU_ADD;
            end
            ST_DECODE: begin
                ctrl_for.alu_src_b = SRCB_IMM_SH;
                ctrl_for.alu_op    = ALU_ADD;
            end
            ST_EXECUTE: begin
                ctrl_for.alu_src_a = 1'b1;
                ctrl_for.alu_src_b = w_is_r ? SRCB_RT : SRCB_IMM;
                if (w_is_r)              ctrl_for.alu_op = ALU_SUB;
                else if (w_op == OP_ORI)  ctrl_for.alu_op = ALU_OR;
                else if (w_op == OP_SLTI) ctrl_for.alu_op = ALU_SLT;
                else                     ctrl_for.alu_op = ALU_ADD;
            end
            ST_ALU_WB: begin
                ctrl_for.reg_write = 1'b1;
                ctrl_for.reg_dst   = w_is_r;
                ctrl_for.move      = w_is_move;
            end
            ST_ADDR: begin
                ctrl_for.alu_src_a = 1'b1;
                ctrl_for.alu_src_b = SRCB_IMM;
                ctrl_for.alu_op    = ALU_ADD;
            end
            ST_MEM: begin
                ctrl_for.mem_req = 1'b1;
                ctrl_for.i_or_d  = 1'b1;
                ctrl_for.mem_we  = w_is_store;
                ctrl_for.byte_op = w_is_byte;
            end
            ST_LOAD_WB: begin
                ctrl_for.reg_write  = 1'b1;
                ctrl_for.mem_to_reg = 1'b1;
                ctrl_for.byte_op    = w_is_byte;
            end
            ST_BRANCH: begin
                ctrl_for.alu_src_a = 1'b1;
                ctrl_for.alu_src_b = SRCB_RT;
                ctrl_for.alu_op    = ALU_SUB;
                ctrl_for.pc_src    = PCSRC_ALUOUT;
                ctrl_for.branch    = 1'b1;
            end
            ST_JUMP: begin
                ctrl_for.pc_src   = PCSRC_JUMP;
                ctrl_for.pc_write = 1'b1;
            end
            default: ;
        endcase
    endfunction

    assign w_next = next_state(r_state, mem_ready, r_wait_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_ctrl     <= ctrl_for(ST_FETCH);
            r_trap     <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next);
            r_trap  <= (w_next == ST_TRAP);
            if ((w_next != r_state) || mem_ready)
                r_wait_cnt <= '0;
            else if ((r_state == ST_FETCH) || (r_state == ST_MEM))
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Every output is forced low while reset is asserted, including the live-qualified enables
    assign w_out   = rst_n ? r_ctrl : '0;
    assign w_taken = ((w_op == OP_BEQ) & zero) | ((w_op == OP_BNE) & ~zero);

    assign mem_req    = w_out.mem_req;
    assign mem_we     = w_out.mem_we;
    assign i_or_d     = w_out.i_or_d;
    assign ir_write   = w_out.fetch & mem_ready;
    assign pc_write   = w_out.pc_write | (w_out.fetch & mem_ready) | (w_out.branch & w_taken);
    assign reg_dst    = w_out.reg_dst;
    assign mem_to_reg = w_out.mem_to_reg;
    assign reg_write  = w_out.reg_write;
    assign alu_src_a  = w_out.alu_src_a;
    assign alu_src_b  = w_out.alu_src_b;
    assign alu_op     = ALUOP_W'(w_out.alu_op);
    assign pc_src     = w_out.pc_src;
    assign byte_op    = w_out.byte_op;
    assign move       = w_out.move;
    assign trap       = rst_n & r_trap;
    assign state_o    = rst_n ? r_state : 4'd0;

endmodule

`default_nettype wire
